// File: rtl/axi_line_pkg.sv
// axi_line_pkg: shared states, AXI constants and address helper for the line master
package axi_line_pkg;
  typedef enum logic [2:0] {IDLE, AR, R, AW, W, B, RESP} state_t;
  localparam logic [2:0] SIZE_8B = 3'd3;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  function automatic logic [63:0] line_align(input logic [63:0] addr, input int unsigned lsb);
    return addr & ~((64'd1 << lsb) - 64'd1);
  endfunction
endpackage

// File: rtl/axi_line_buf.sv
// axi_line_buf: line-wide beat buffer, bulk-loaded per request, written per R beat, read per W beat
module axi_line_buf #(
  parameter int BEATS = 4,
  parameter int IW = $clog2(BEATS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [BEATS*64-1:0]   load_line,
  input  logic                  we,
  input  logic [IW-1:0]         widx,
  input  logic [63:0]           wbeat,
  input  logic [IW-1:0]         sidx,
  output logic [63:0]           sbeat,
  output logic [BEATS*64-1:0]   line
);
  logic [BEATS-1:0][63:0] mem;
  // whole-line load on request capture, otherwise single-beat update
  always_ff @(posedge clk or posedge rst)
    if (rst) mem <= '0;
    else if (load) mem <= load_line;
    else if (we) mem[widx] <= wbeat;
  assign sbeat = mem[sidx];
  assign line = mem;
endmodule

// File: rtl/axi_line_master.sv
// axi_line_master: turns cache line/word requests into single-outstanding AXI4 bursts
module axi_line_master import axi_line_pkg::*; #(
  parameter int AXI_ADDR_W = 64,
  parameter int AXI_ID_W = 8,
  parameter int AXI_DATA_W = 64,
  parameter int BEATS = 4,
  parameter int MST_ID = 0
) (
  input  logic                    aclk,
  input  logic                    arst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic                    req_single,
  input  logic                    req_lock,
  input  logic [AXI_ADDR_W-1:0]   req_addr,
  input  logic [BEATS*64-1:0]     req_wdata,
  input  logic [7:0]              req_wstrb,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [BEATS*64-1:0]     resp_rdata,
  output logic                    resp_err,
  output logic                    resp_exfail,
  output logic                    mst_awvalid,
  input  logic                    mst_awready,
  output logic [AXI_ADDR_W-1:0]   mst_awaddr,
  output logic [7:0]              mst_awlen,
  output logic [2:0]              mst_awsize,
  output logic [1:0]              mst_awburst,
  output logic                    mst_awlock,
  output logic [3:0]              mst_awcache,
  output logic [2:0]              mst_awprot,
  output logic [3:0]              mst_awqos,
  output logic [3:0]              mst_awregion,
  output logic [AXI_ID_W-1:0]     mst_awid,
  output logic                    mst_wvalid,
  output logic                    mst_wlast,
  output logic [AXI_DATA_W-1:0]   mst_wdata,
  output logic [7:0]              mst_wstrb,
  input  logic                    mst_wready,
  input  logic                    mst_bvalid,
  input  logic [AXI_ID_W-1:0]     mst_bid,
  input  logic [1:0]              mst_bresp,
  output logic                    mst_bready,
  output logic                    mst_arvalid,
  input  logic                    mst_arready,
  output logic [AXI_ADDR_W-1:0]   mst_araddr,
  output logic [7:0]              mst_arlen,
  output logic [2:0]              mst_arsize,
  output logic [1:0]              mst_arburst,
  output logic                    mst_arlock,
  output logic [3:0]              mst_arcache,
  output logic [2:0]              mst_arprot,
  output logic [3:0]              mst_arqos,
  output logic [3:0]              mst_arregion,
  output logic [AXI_ID_W-1:0]     mst_arid,
  input  logic                    mst_rvalid,
  input  logic [AXI_ID_W-1:0]     mst_rid,
  input  logic [1:0]              mst_rresp,
  input  logic [AXI_DATA_W-1:0]   mst_rdata,
  input  logic                    mst_rlast,
  output logic                    mst_rready
);
  localparam int IW = $clog2(BEATS);
  localparam int CW = IW + 1;
  localparam int LW = $clog2(BEATS * 8);
  state_t state, nxt;
  logic r_write, r_single, r_lock, err, exfail, req_hs, r_hs, w_hs, b_hs;
  logic [AXI_ADDR_W-1:0] r_addr;
  logic [7:0] r_wstrb;
  logic [CW-1:0] cnt, len;
  assign req_hs = req_valid && state == IDLE;
  assign r_hs = mst_rvalid && state == R && mst_rid == AXI_ID_W'(MST_ID);
  assign w_hs = mst_wready && state == W;
  assign b_hs = mst_bvalid && state == B && mst_bid == AXI_ID_W'(MST_ID);
  assign len = r_single ? '0 : CW'(BEATS - 1);
  assign mst_awaddr = r_addr;
  assign mst_araddr = r_addr;
  assign mst_awlen = 8'(len);
  assign mst_arlen = 8'(len);
  assign mst_awsize = SIZE_8B;
  assign mst_arsize = SIZE_8B;
  assign mst_awburst = BURST_INCR;
  assign mst_arburst = BURST_INCR;
  assign mst_awlock = r_lock;
  assign mst_arlock = r_lock;
  assign mst_awcache = '0;
  assign mst_arcache = '0;
  assign mst_awprot = '0;
  assign mst_arprot = '0;
  assign mst_awqos = '0;
  assign mst_arqos = '0;
  assign mst_awregion = '0;
  assign mst_arregion = '0;
  assign mst_awid = AXI_ID_W'(MST_ID);
  assign mst_arid = AXI_ID_W'(MST_ID);
  assign mst_wstrb = r_single ? r_wstrb : 8'hFF;
  assign mst_wlast = cnt == len;
  assign resp_err = err;
  assign resp_exfail = exfail;
  axi_line_buf #(.BEATS(BEATS)) u_buf (
    .clk(aclk),
    .rst(arst),
    .load(req_hs),
    .load_line(req_write ? req_wdata : '0),
    .we(r_hs && !cnt[IW]),
    .widx(cnt[IW-1:0]),
    .wbeat(mst_rdata),
    .sidx(cnt[IW-1:0]),
    .sbeat(mst_wdata),
    .line(resp_rdata)
  );
  // state register
  always_ff @(posedge aclk or posedge arst)
    if (arst) state <= IDLE;
    else state <= nxt;
  // request capture, beat counter and completion status
  always_ff @(posedge aclk or posedge arst)
    if (arst) begin
      {r_write, r_single, r_lock, err, exfail} <= '0;
      r_addr <= '0;
      r_wstrb <= '0;
      cnt <= '0;
    end else begin
      if (req_hs) begin
        r_write <= req_write;
        r_single <= req_single;
        r_lock <= req_lock && req_single;
        r_addr <= req_single ? {req_addr[AXI_ADDR_W-1:3], 3'b0} : AXI_ADDR_W'(line_align(64'(req_addr), LW));
        r_wstrb <= req_wstrb;
      end
      if (r_hs) begin
        cnt <= cnt + CW'(1);
        err <= err | mst_rresp[1] | (mst_rlast && cnt != len);
        exfail <= exfail | (r_lock && mst_rresp != RESP_EXOKAY);
      end
      if (w_hs) cnt <= cnt + CW'(1);
      if (b_hs) begin
        err <= !r_lock && mst_bresp[1];
        exfail <= r_lock && mst_bresp != RESP_EXOKAY;
      end
      if (state == RESP && resp_ready) begin
        err <= 1'b0;
        exfail <= 1'b0;
        cnt <= '0;
      end
    end
  // next state and handshake outputs
  always_comb begin
    nxt = state;
    req_ready = 1'b0;
    mst_arvalid = 1'b0;
    mst_rready = 1'b0;
    mst_awvalid = 1'b0;
    mst_wvalid = 1'b0;
    mst_bready = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        nxt = req_valid ? (req_write ? AW : AR) : IDLE;
      end
      AR: begin
        mst_arvalid = 1'b1;
        nxt = mst_arready ? R : AR;
      end
      R: begin
        mst_rready = 1'b1;
        nxt = r_hs && mst_rlast ? RESP : R;
      end
      AW: begin
        mst_awvalid = 1'b1;
        nxt = mst_awready ? W : AW;
      end
      W: begin
        mst_wvalid = 1'b1;
        nxt = w_hs && mst_wlast ? B : W;
      end
      B: begin
        mst_bready = 1'b1;
        nxt = b_hs ? RESP : B;
      end
      RESP: begin
        resp_valid = 1'b1;
        nxt = resp_ready ? IDLE : RESP;
      end
      default: nxt = IDLE;
    endcase
  end
endmodule

// File: doc/axi_line_master.md
Name: axi_line_master

Overview:
- AXI4 master that turns cache-side line/word requests into AXI bursts toward the simulation SRAM slave on the mst_* bus.
- Line mode moves BEATS x 64-bit beats with INCR bursts; single mode moves one beat, optionally exclusive (LR/SC).
- Sits between the L1 cache miss/writeback logic and the AXI memory slave.
- One transaction outstanding at a time.

Parameters:
AXI_ADDR_W, 64, address width
AXI_ID_W, 8, ID width
AXI_DATA_W, 64, data width (fixed 64; size field = 3)
BEATS, 4, beats per line (power of 2, 2..16)
MST_ID, 0, constant value driven on awid/arid

Ports:
aclk  in  1  clock
arst  in  1  reset, asynchronous, active-high
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&ready
req_write  in  1  1=write, 0=read
req_single  in  1  1=single beat, 0=full line
req_lock  in  1  exclusive (LR/SC); only legal with req_single=1
req_addr  in  AXI_ADDR_W  byte address
req_wdata  in  BEATS*64  write line; beat i = bits [64i+63:64i]; single uses beat 0
req_wstrb  in  8  byte strobe for single write
resp_valid  out  1  completion valid, held until resp_ready
resp_ready  in  1  completion accepted
resp_rdata  out  BEATS*64  read line; single read fills beat 0, other beats 0
resp_err  out  1  SLVERR/DECERR on a non-exclusive access, or beat-count mismatch
resp_exfail  out  1  exclusive access not answered with EXOKAY
mst_aw*  out/in  AXI4  awvalid out, awready in, awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awqos/awregion/awid out
mst_w*  out/in  AXI4  wvalid/wlast/wdata/wstrb out, wready in
mst_b*  in/out  AXI4  bvalid/bid/bresp in, bready out
mst_ar*  out/in  AXI4  arvalid out, arready in, araddr/arlen/arsize/arburst/arlock/arcache/arprot/arqos/arregion/arid out
mst_r*  in/out  AXI4  rvalid/rid/rresp/rdata/rlast in, rready out

Behaviour:
- Reset state: IDLE, all valids low (awvalid, wvalid, arvalid, resp_valid), bready=0, rready=0, resp_rdata=0, resp_err=0, resp_exfail=0, beat counter 0.
- Constant AXI fields: awsize=arsize=3, burst=INCR (2'b01), cache=prot=qos=region=0, id=MST_ID.
- Address/length:
  - Line mode: address = req_addr with low log2(BEATS*8) bits cleared, len=BEATS-1, wstrb=8'hFF.
  - Single mode: address = req_addr with low 3 bits cleared, len=0, wstrb=req_wstrb.
  - awlock/arlock = req_lock.
- req_ready=1 only in IDLE. The request is captured in registers on handshake.
- States:
  - IDLE: on handshake go to AR (read) or AW (write).
  - AR: arvalid=1, held stable until arready, then go to R.
  - R: rready=1. Each beat is stored at counter index and the counter increments. On the rlast beat go to RESP.
    - Counter != len at rlast sets err.
    - rresp accumulates: any bit1 set gives err; for lock, rresp!=01 gives exfail.
  - AW: awvalid=1 until awready, then go to W. wvalid is not asserted before AW completes, because the slave only accepts W after AW.
  - W: wvalid=1, wdata = beat[counter], wlast = (counter==len). The counter advances on wready. After the last handshake go to B.
  - B: bready=1. On bvalid, capture bresp and go to RESP.
    - lock: exfail = (bresp!=01), err=0.
    - non-lock: err = bresp[1].
  - RESP: resp_valid=1 until resp_ready, then go to IDLE and clear err/exfail/counter.
- Latency: the earliest completion is 1 cycle after the last R/B handshake. Back-to-back requests need one IDLE cycle.
- Stray or ID-mismatched R/B beats are ignored (rready=0/bready=0 outside R/B).
- req_lock with req_single=0: the request is treated as non-exclusive (lock forced 0).
- Reset asserted mid-transaction: immediate return to reset state; the in-flight burst is abandoned. Reset must only be applied with the slave also in reset.

Decomposition:
- Package axi_line_pkg holds:
  - state enum IDLE/AR/R/AW/W/B/RESP
  - AXI constants: SIZE_8B=3, BURST_INCR=2'b01, RESP_OKAY/EXOKAY/SLVERR/DECERR
  - function line_align(addr).
- One natural sub-module: axi_line_buf, a BEATS x 64 beat buffer with indexed write and per-beat select. It is shared by the R-capture and W-drive paths.

Test Plan:
- Line read at req_addr=0x8000_0018 with BEATS=4 -> araddr=0x8000_0000, arlen=3, 4 beats 0x11..0x44 returned in order, resp_rdata={0x44,0x33,0x22,0x11}, err=0.
- Line write at 0x8000_0040 -> awlen=3, 4 W beats with wstrb=FF, wlast only on beat 3, B OKAY, resp_valid once.
- Single write at 0x8000_0105 with wstrb=0x0F -> awaddr=0x8000_0100, awlen=0, wlast=1 on the first beat.
- LR at 0x100, then SC at 0x100 -> EXOKAY, exfail=0. A second SC to 0x100 -> bresp=3, exfail=1, err=0.
- Slave stalls: awready low 5 cycles, rvalid gaps, resp_ready low 3 cycles -> all outputs held stable, no beat lost or duplicated.
- rlast on beat 2 of a 4-beat read -> resp_err=1. Reset asserted in W state -> wvalid=0 the same cycle and req_ready=1 after reset deasserts.
